slot_frame_collector: RTL

- Receive end of the 2-bit slot-sequenced audio sample stream. An upstream free-running 2-bit slot counter tags each sample with a slot index 0..3.
- This block checks the index sequence, collects slots 0..3 into one 4-slot frame, and presents the frame downstream on a valid/ready handshake.
- Sits between the slot-tagged sample source and the frame consumer (mixer/output stage).

---
 rtl/audio_slot_pkg.sv | 17 +
 rtl/frame_out_reg.sv | 46 ++++
 rtl/slot_frame_collector.sv | 100 ++++++++++
 3 files changed

// File: rtl/audio_slot_pkg.sv
// rtl/audio_slot_pkg.sv - shared slot constants, collector state and slot bit-offset helper
package audio_slot_pkg;

    localparam int SLOT_IDX_W = 2;
    localparam int NUM_SLOTS  = 4;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Slot n occupies bits [n*data_w +: data_w] of a packed frame.
    function automatic int slot_lsb(input logic [SLOT_IDX_W-1:0] n, input int data_w);
        return int'(n) * data_w;
    endfunction

endpackage

// File: rtl/frame_out_reg.sv
// rtl/frame_out_reg.sv - valid/ready frame holding register with dropped-frame (overrun) pulse
module frame_out_reg
    import audio_slot_pkg::*;
#(
    parameter int FRAME_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_data,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [FRAME_W-1:0] o_data,
    output logic               o_overrun
);

    logic               r_valid;
    logic [FRAME_W-1:0] r_data;
    logic               r_overrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A held frame that is not being taken this cycle wins; the new one is lost.
                if (!r_valid || i_ready) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/slot_frame_collector.sv
// rtl/slot_frame_collector.sv - checks slot index sequence and collects slots 0..3 into frames
module slot_frame_collector
    import audio_slot_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        slot_valid,
    input  logic [SLOT_IDX_W-1:0]       slot_idx,
    input  logic [DATA_W-1:0]           slot_data,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [NUM_SLOTS*DATA_W-1:0] frame_data,
    output logic                        seq_err,
    output logic                        overrun
);

    localparam int                    FRAME_W  = NUM_SLOTS * DATA_W;
    localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(NUM_SLOTS - 1);

    state_t                r_state;
    logic [SLOT_IDX_W-1:0] r_exp_idx;
    logic [FRAME_W-1:0]    r_buf;
    logic                  r_seq_err;

    logic                  w_in_seq;
    logic                  w_frame_done;
    logic [FRAME_W-1:0]    w_frame_word;

    assign w_in_seq     = slot_valid && (r_state == COLLECT) && (slot_idx == r_exp_idx);
    assign w_frame_done = w_in_seq && (r_exp_idx == LAST_IDX);

    // The last slot bypasses the collect buffer so the frame reaches the output register directly.
    always_comb begin
        w_frame_word = r_buf;
        w_frame_word[slot_lsb(LAST_IDX, DATA_W) +: DATA_W] = slot_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SYNC;
            r_exp_idx <= '0;
            r_buf     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            if (slot_valid) begin
                case (r_state)
                    SYNC: begin
                        if (slot_idx == '0) begin
                            r_buf[slot_lsb(slot_idx, DATA_W) +: DATA_W] <= slot_data;
                            r_exp_idx <= SLOT_IDX_W'(1);
                            r_state   <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (w_in_seq) begin
                            r_buf[slot_lsb(slot_idx, DATA_W) +: DATA_W] <= slot_data;
                            r_exp_idx <= r_exp_idx + SLOT_IDX_W'(1);
                            if (w_frame_done) begin
                                r_state <= SYNC;
                            end
                        end else begin
                            r_seq_err <= 1'b1;
                            // An unexpected slot 0 is taken as the start of a fresh frame.
                            if (slot_idx == '0) begin
                                r_buf[slot_lsb(slot_idx, DATA_W) +: DATA_W] <= slot_data;
                                r_exp_idx <= SLOT_IDX_W'(1);
                            end else begin
                                r_exp_idx <= '0;
                                r_state   <= SYNC;
                            end
                        end
                    end
                    default: begin
                        r_state   <= SYNC;
                        r_exp_idx <= '0;
                    end
                endcase
            end
        end
    end

    frame_out_reg #(
        .FRAME_W(FRAME_W)
    ) u_frame_out_reg (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_load    (w_frame_done),
        .i_data    (w_frame_word),
        .i_ready   (frame_ready),
        .o_valid   (frame_valid),
        .o_data    (frame_data),
        .o_overrun (overrun)
    );

    assign seq_err = r_seq_err;

endmodule
